// File: rtl/tile_scan_sequencer_if.sv
// Result port of the tile scan sequencer: valid/ready handshake carrying the
// captured tile byte and its tile index. With SCAN_TIMESTAMP_EN defined the
// port also carries the 16-bit capture timestamp res_ts.
interface tile_scan_sequencer_if;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic [1:0]  res_tile;
`ifdef SCAN_TIMESTAMP_EN
    logic [15:0] res_ts;

    modport master (output res_valid, output res_data, output res_tile, output res_ts,
                    input res_ready);
    modport slave  (input res_valid, input res_data, input res_tile, input res_ts,
                    output res_ready);
`else
    modport master (output res_valid, output res_data, output res_tile,
                    input res_ready);
    modport slave  (input res_valid, input res_data, input res_tile,
                    output res_ready);
`endif
endinterface

// File: rtl/tile_scan_sequencer.sv
// Tile scan sequencer: time-shares the micro-tile container's single output
// byte among its tiles. Each enabled tile is held in reset, released, allowed
// to settle for dwell cycles, then its byte is captured and handed downstream
// tagged with the tile index. Only one tile is ever out of reset.
// Optional feature: define SCAN_TIMESTAMP_EN to add a free-running 16-bit
// cycle counter whose value is captured with each result on res.res_ts.
module tile_scan_sequencer #(
    parameter int RST_CYCLES = 4,
    parameter int NUM_TILES  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       cont,
    input  logic [3:0] mask,
    input  logic [7:0] dwell,
    input  logic [7:0] tile_data,
    output logic [1:0] sel,
    output logic [3:0] tile_rst_n,
    output logic [3:0] tile_clk_en,
    output logic       busy,
    tile_scan_sequencer_if.master res
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_SETTLE,
        S_CAPTURE,
        S_HOLD,
        S_NEXT
    } state_t;

    state_t     state;
    logic [3:0] mask_q;
    logic [7:0] dwell_q;
    logic       cont_q;
    logic [7:0] cnt;
    logic [1:0] first_req;
    logic [1:0] first_q;
    logic [2:0] next_info;

    // A zero dwell would leave no settle cycle at all, so it is clamped to 1.
    function automatic logic [7:0] clamp_dwell(input logic [7:0] d);
        return (d == 8'd0) ? 8'd1 : d;
    endfunction

    // Index of the lowest set bit; only meaningful for a non-zero mask.
    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_TILES - 1; i >= 0; i--) begin
            if (m[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // {found, index} of the lowest set bit strictly above c.
    function automatic logic [2:0] next_set(input logic [3:0] m, input logic [1:0] c);
        logic       found;
        logic [1:0] idx;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = NUM_TILES - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(c))) begin
                found = 1'b1;
                idx   = 2'(i);
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    // Tile-order lookups for the start request and for advancing in NEXT.
    always_comb begin
        first_req = lowest_set(mask);
        first_q   = lowest_set(mask_q);
        next_info = next_set(mask_q, sel);
    end

    // Scan FSM with registered select, tile reset/enable and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            sel           <= 2'd0;
            tile_rst_n    <= 4'b0000;
            tile_clk_en   <= 4'b0000;
            res.res_valid <= 1'b0;
            res.res_data  <= 8'd0;
            res.res_tile  <= 2'd0;
            busy          <= 1'b0;
            mask_q        <= 4'd0;
            dwell_q       <= 8'd1;
            cont_q        <= 1'b0;
            cnt           <= 8'd0;
        end else if (abort) begin
            // Abort overrides everything, including a simultaneous start.
            state         <= S_IDLE;
            tile_rst_n    <= 4'b0000;
            tile_clk_en   <= 4'b0000;
            res.res_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && (mask != 4'd0)) begin
                        mask_q      <= mask;
                        dwell_q     <= clamp_dwell(dwell);
                        cont_q      <= cont;
                        sel         <= first_req;
                        tile_rst_n  <= 4'b0000;
                        tile_clk_en <= onehot(first_req);
                        cnt         <= 8'(RST_CYCLES - 1);
                        busy        <= 1'b1;
                        state       <= S_RST;
                    end
                end
                S_RST: begin
                    if (cnt == 8'd0) begin
                        tile_rst_n <= onehot(sel);
                        cnt        <= dwell_q - 8'd1;
                        state      <= S_SETTLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_SETTLE: begin
                    if (cnt == 8'd0) begin
                        state <= S_CAPTURE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                S_CAPTURE: begin
                    res.res_data  <= tile_data;
                    res.res_tile  <= sel;
                    res.res_valid <= 1'b1;
                    tile_rst_n    <= 4'b0000;
                    tile_clk_en   <= 4'b0000;
                    state         <= S_HOLD;
                end
                S_HOLD: begin
                    if (res.res_valid && res.res_ready) begin
                        res.res_valid <= 1'b0;
                        state         <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (next_info[2]) begin
                        sel         <= next_info[1:0];
                        tile_clk_en <= onehot(next_info[1:0]);
                        cnt         <= 8'(RST_CYCLES - 1);
                        state       <= S_RST;
                    end else if (cont_q) begin
                        sel         <= first_q;
                        tile_clk_en <= onehot(first_q);
                        cnt         <= 8'(RST_CYCLES - 1);
                        state       <= S_RST;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SCAN_TIMESTAMP_EN
    logic [15:0] ts_cnt;

    // Free-running cycle counter; wraps naturally from 16'hFFFF to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt <= 16'd0;
        end else begin
            ts_cnt <= ts_cnt + 16'd1;
        end
    end

    // Timestamp is captured in the same cycle as the tile byte and held with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res.res_ts <= 16'd0;
        end else if (!abort && (state == S_CAPTURE)) begin
            res.res_ts <= ts_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_tile_scan_sequencer.sv
// Self-checking bench for tile_scan_sequencer. A scoreboard holds the expected
// tile order and timing rules; one compare process checks outputs every cycle.
module tb_tile_scan_sequencer;
    localparam int RST_CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       cont = 1'b0;
    logic [3:0] mask = 4'd0;
    logic [7:0] dwell = 8'd0;
    logic [7:0] tile_data;
    logic [1:0] sel;
    logic [3:0] tile_rst_n;
    logic [3:0] tile_clk_en;
    logic       busy;

    tile_scan_sequencer_if rif();

    assign tile_data = 8'hA0 + {6'd0, sel};

    tile_scan_sequencer #(.RST_CYCLES(RST_CYCLES), .NUM_TILES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .cont       (cont),
        .mask       (mask),
        .dwell      (dwell),
        .tile_data  (tile_data),
        .sel        (sel),
        .tile_rst_n (tile_rst_n),
        .tile_clk_en(tile_clk_en),
        .busy       (busy),
        .res        (rif)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard configuration, written only by the driver.
    int         exp_order[$];
    bit         exp_cont = 1'b0;
    logic [3:0] exp_mask = 4'd0;
    int         exp_first = -1;
    int         exp_gap = 0;
    int         scan_id = 0;
    int         launch_cyc = 0;
    int         rel_cyc = 0;

    // Observation state, written only by the compare process.
    int         seen_id = 0;
    int         pos = 0;
    int         rises = 0;
    int         results = 0;
    int         first_rise = 0;
    int         last_rise = 0;
    int         last_gap = 0;
    int         busy_fall = -1;
    bit         pv = 1'b0;
    bit         pr = 1'b0;
    bit         pbusy = 1'b0;
    logic [7:0] pd = 8'd0;
    logic [1:0] pt = 2'd0;
    logic [1:0] psel = 2'd0;
    logic [3:0] ptrn = 4'd0;
`ifdef SCAN_TIMESTAMP_EN
    logic [15:0] prev_ts = 16'd0;
    int          ts_wraps = 0;
`endif

    // Compare process: samples on the falling edge, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            pv = 1'b0; pr = 1'b0; pbusy = 1'b0; psel = 2'd0; ptrn = 4'd0;
        end else begin
            if (seen_id != scan_id) begin
                seen_id = scan_id; pos = 0; rises = 0; results = 0; busy_fall = -1;
`ifdef SCAN_TIMESTAMP_EN
                ts_wraps = 0;
`endif
            end
            // Tile isolation: at most one live tile, it is the selected one, and it is enabled.
            if (tile_rst_n != 4'd0) begin
                check("one_tile_out_of_reset", $countones(tile_rst_n), 1);
                check("live_tile_is_selected", tile_rst_n, 4'b0001 << sel);
            end
            check("disabled_tiles_quiet", (tile_rst_n | tile_clk_en) & ~exp_mask, 0);
            if (sel != psel) check("sel_moves_only_in_reset", ptrn | tile_rst_n, 0);
            // Result must stay put while stalled.
            if (pv && !pr) begin
                check("stall_valid_held", rif.res_valid, 1);
                check("stall_data_held", rif.res_data, pd);
                check("stall_tile_held", rif.res_tile, pt);
                check("stall_tiles_in_reset", tile_rst_n, 0);
                check("stall_sel_held", sel, psel);
            end
            if (rif.res_valid && !pv) begin
                if (rises == 0) begin
                    if (exp_first > 0) check("first_result_cycle", cyc, exp_first);
                    first_rise = cyc;
                end else begin
                    last_gap = cyc - last_rise;
                    if (exp_gap > 0) check("result_spacing", last_gap, exp_gap);
                end
`ifdef SCAN_TIMESTAMP_EN
                check("res_ts_capture", rif.res_ts, 16'(cyc - 1 - rel_cyc));
                if (rises > 0 && exp_gap > 0) check("res_ts_spacing", 16'(rif.res_ts - prev_ts), exp_gap);
                if (rises > 0 && rif.res_ts < prev_ts) ts_wraps++;
                prev_ts = rif.res_ts;
`endif
                last_rise = cyc;
                rises++;
            end
            if (rif.res_valid && rif.res_ready) begin
                if (pos < exp_order.size()) begin
                    check("res_tile_order", rif.res_tile, exp_order[pos]);
                    check("res_data_value", rif.res_data, 8'hA0 + exp_order[pos]);
                    pos++;
                    if (pos == exp_order.size() && exp_cont) pos = 0;
                end else begin
                    check("result_count", pos + 1, exp_order.size());
                end
                results++;
            end
            if (pbusy && !busy) busy_fall = cyc;
            pv = rif.res_valid; pr = rif.res_ready; pd = rif.res_data; pt = rif.res_tile;
            psel = sel; ptrn = tile_rst_n; pbusy = busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_sel"}, sel, 0);
        check({tag, "_tile_rst_n"}, tile_rst_n, 0);
        check({tag, "_tile_clk_en"}, tile_clk_en, 0);
        check({tag, "_res_valid"}, rif.res_valid, 0);
        check({tag, "_res_data"}, rif.res_data, 0);
        check({tag, "_res_tile"}, rif.res_tile, 0);
        check({tag, "_busy"}, busy, 0);
`ifdef SCAN_TIMESTAMP_EN
        check({tag, "_res_ts"}, rif.res_ts, 0);
`endif
    endtask

    task automatic release_reset();
        tick();
        rst_n = 1'b1;
        rel_cyc = cyc;
    endtask

    // Builds the expected sweep from the mask and pulses start.
    task automatic launch(input logic [3:0] m, input logic [7:0] d, input logic c, input bit timed);
        int deff;
        deff = (d == 8'd0) ? 1 : int'(d);
        exp_order.delete();
        for (int i = 0; i < 4; i++) if (m[i]) exp_order.push_back(i);
        exp_cont = c;
        exp_mask = m;
        tick();
        launch_cyc = cyc;
        exp_first = timed ? (cyc + RST_CYCLES + deff + 2) : -1;
        exp_gap = timed ? (RST_CYCLES + deff + 3) : 0;
        scan_id++;
        mask = m; dwell = d; cont = c; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_busy_low(input string tag, input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin tick(); n++; end
        tick();
        check({tag, "_scan_ends"}, busy, 0);
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int n;
        n = 0;
        while (!rif.res_valid && n < limit) begin tick(); n++; end
        check({tag, "_valid_seen"}, rif.res_valid, 1);
    endtask

    initial begin
        int s;
        int n;
        rif.res_ready = 1'b1;
        repeat (3) tick();
        check_reset_values("in_reset");
        release_reset();
        tick();
        check_reset_values("after_reset");

        // Full sweep, dwell 2: results 9 cycles apart, first 8 cycles after start.
        launch(4'b1111, 8'd2, 1'b0, 1'b1);
        wait_busy_low("t1", 200);
        check("t1_results", results, 4);
        check("t1_first_latency", first_rise - launch_cyc, 8);
        check("t1_spacing", last_gap, 9);
        check("t1_busy_drop", busy_fall - last_rise, 2);

        // Sparse mask, dwell 0 behaves as dwell 1.
        launch(4'b1010, 8'd0, 1'b0, 1'b1);
        wait_busy_low("t2", 200);
        check("t2_results", results, 2);
        check("t2_first_latency", first_rise - launch_cyc, 7);
        check("t2_spacing", last_gap, 8);

        // Downstream stall of 20 cycles on the first result.
        rif.res_ready = 1'b0;
        launch(4'b1111, 8'd2, 1'b0, 1'b0);
        wait_valid("t3", 60);
        repeat (20) tick();
        check("t3_still_valid", rif.res_valid, 1);
        check("t3_no_handshake", results, 0);
        rif.res_ready = 1'b1;
        s = cyc;
        tick();
        check("t3_valid_drops", rif.res_valid, 0);
        tick();
        check("t3_next_tile_sel", sel, 1);
        check("t3_next_tile_clk_en", tile_clk_en, 4'b0010);
        wait_valid("t3_resume", 60);
        check("t3_resume_latency", cyc - s, 9);
        wait_busy_low("t3", 200);
        check("t3_results", results, 4);

        // Continuous single tile, then abort during SETTLE.
        launch(4'b0100, 8'd2, 1'b1, 1'b1);
        n = 0;
        while (results < 3 && n < 300) begin tick(); n++; end
        check("t4_repeats", results >= 3, 1);
        n = 0;
        while (tile_rst_n != 4'b0100 && n < 30) begin tick(); n++; end
        check("t4_settle_found", tile_rst_n, 4'b0100);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_abort_busy", busy, 0);
        check("t4_abort_tile_rst_n", tile_rst_n, 0);
        check("t4_abort_tile_clk_en", tile_clk_en, 0);
        check("t4_abort_valid", rif.res_valid, 0);
        repeat (5) tick();
        check("t4_stays_idle", busy, 0);
        mask = 4'b1111; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        check("t4_start_with_abort_ignored", busy, 0);

        // Start with empty mask, then restart attempts and input changes mid-scan.
        exp_mask = 4'd0;
        mask = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_empty_mask_busy", busy, 0);
        repeat (3) tick();
        check("t5_empty_mask_tiles", tile_rst_n | tile_clk_en, 0);
        launch(4'b1111, 8'd2, 1'b0, 1'b1);
        n = 0;
        while (results < 1 && n < 60) begin tick(); n++; end
        mask = 4'b0001; dwell = 8'd9; cont = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_busy_low("t5", 300);
        check("t5_results", results, 4);
        check("t5_spacing", last_gap, 9);
        cont = 1'b0;

        // Asynchronous reset in the middle of a scan.
        launch(4'b1111, 8'd2, 1'b0, 1'b1);
        n = 0;
        while (tile_rst_n == 4'd0 && n < 40) begin tick(); n++; end
        check("t6_tile_live", tile_rst_n != 4'd0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        tick();
        release_reset();
        tick();
        check("t6_idle_after_reset", busy, 0);

`ifdef SCAN_TIMESTAMP_EN
        // Timestamp spacing of 10 cycles for dwell 3, run across counter wrap.
        launch(4'b0001, 8'd3, 1'b1, 1'b1);
        n = 0;
        while (ts_wraps == 0 && n < 70000) begin tick(); n++; end
        check("ts_wrapped", ts_wraps > 0, 1);
        repeat (25) tick();
        check("ts_last_spacing", last_gap, 10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ts_abort_busy", busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tile_scan_sequencer.md
Name: tile_scan_sequencer

Overview:
Scheduler that time-shares the micro-tile container's single 8-bit output among its four tiles: sensor, TDC, RO, RO2. The block drives the tile select and per-tile reset and clock-enable. For each enabled tile it holds the tile in reset, releases it, waits a programmable dwell, then captures the muxed tile byte. Each result is handed downstream through a valid/ready port tagged with the tile index. It sits between the container's select/reset fan-out and the host-side readout logic.

Parameters:
RST_CYCLES, 4, cycles each tile is held in reset before release (1..15)
NUM_TILES, 4, number of tiles scheduled; the tile index is 2 bits wide

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse that begins a scan
abort  input  1  level; stops the scan and returns to IDLE
cont  input  1  1 = continuous scanning; 0 = a single sweep
mask  input  4  tile enable mask; bit i enables tile i
dwell  input  8  settle cycles after reset release before capture
tile_data  input  8  muxed tile output byte (container uo_out)
sel  output  2  tile select to the container
tile_rst_n  output  4  per-tile active-low reset
tile_clk_en  output  4  per-tile clock enable
res_valid  output  1  result valid
res_ready  input  1  downstream accepts the result
res_data  output  8  captured byte
res_tile  output  2  tile index of res_data
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: sel=0, tile_rst_n=4'b0000, tile_clk_en=0, res_valid=0, res_data=0, res_tile=0, busy=0; state IDLE.
- The following are latched on an accepted start: mask into mask_q; dwell into dwell_q, with dwell=0 stored as 1; cont into cont_q. Input changes during a scan are ignored.
- Start is accepted only in IDLE and only with mask!=0. If mask=0 at start, the block stays in IDLE and busy stays 0. A start pulse while busy is ignored.
- Tile order: ascending index starting at the lowest set bit of mask_q. Disabled tiles are skipped with zero cycles spent on them.
- At most one tile is non-reset at any time. Every other tile has tile_rst_n=0 and tile_clk_en=0.
- States:
  - IDLE: all tiles in reset.
  - RST: sel=cur. tile_rst_n[cur]=0 and tile_clk_en[cur]=1 for RST_CYCLES cycles. Then go to SETTLE.
  - SETTLE: tile_rst_n[cur]=1 for dwell_q cycles. On the last cycle, go to CAPTURE.
  - CAPTURE: one cycle. res_data<=tile_data, res_tile<=cur, res_valid<=1. Tile cur returns to reset on the next cycle. Go to HOLD.
  - HOLD: waits until res_valid && res_ready; the handshake completes in that cycle. res_valid drops the next cycle. Go to NEXT.
  - NEXT: one cycle; advance cur to the next set bit of mask_q.
    - If a next set bit exists, go to RST.
    - If cur wrapped past tile 3 and cont_q=1, go to RST at the lowest set bit.
    - If cur wrapped past tile 3 and cont_q=0, go to IDLE.
- Timing per tile (ready held high): RST_CYCLES + dwell_q + 3 cycles from entering RST to the next RST. Capture is at cycle RST_CYCLES+dwell_q after entering RST.
- res_data and res_tile are stable while res_valid=1. There is no result overwrite: the scan stalls in HOLD until the result is accepted.
- Abort has priority over every transition. On the cycle after abort is seen: state=IDLE, all tiles in reset, res_valid=0, busy=0.
- A start in the same cycle as abort is ignored.
- Asynchronous reset mid-scan forces all reset values immediately.
- sel changes only in NEXT or on leaving IDLE, never while a tile is out of reset.

Optional Feature:
Macro SCAN_TIMESTAMP_EN.
- With the macro defined:
  - A 16-bit free-running cycle counter is added. It resets to 0 and wraps at 16'hFFFF to 0.
  - Its value is captured with each result in the same CAPTURE cycle and presented on output res_ts[15:0].
  - res_ts is held with res_data and resets to 0.
- Without the macro: no counter is built and there is no res_ts port.

Test Plan:
- mask=4'b1111, dwell=2, cont=0, ready=1, tile_data=8'hA0+sel. Required:
  - Four results, tiles 0,1,2,3, with data A0,A1,A2,A3.
  - Results spaced RST_CYCLES+5 cycles apart.
  - busy drops after the last NEXT.
- mask=4'b1010, dwell=0. Required: only tiles 1 then 3; dwell is treated as 1; tiles 0 and 2 never leave reset.
- ready held 0 for 20 cycles after the first CAPTURE. Required:
  - res_valid, res_data and res_tile stay stable.
  - tile_rst_n stays all 0 and sel does not change.
  - The scan resumes one cycle after ready=1.
- cont=1, mask=4'b0100. Required: tile 2 is scanned repeatedly until abort. Abort during SETTLE gives IDLE, tile_rst_n=0 and res_valid=0 on the next cycle.
- Start with mask=0, then start while busy. Required:
  - The first start leaves busy=0.
  - The second start does not restart or perturb the tile order.
  - Changing mask mid-scan has no effect.
- SCAN_TIMESTAMP_EN defined, dwell=3. Required: the difference between consecutive res_ts values equals RST_CYCLES+6 with ready=1, and res_ts wraps correctly across 16'hFFFF.
